// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-serial instruction loader.
// The CHK state is only entered when INSTR_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLen,
      StData,
      StChk,
      StDone,
      StErr
   } loader_state_t;

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/word_assembler.sv
// Merges bytes little-endian into a 32-bit word; flags the byte that completes a word.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;

   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (byte_valid_i) begin
         word_d[{idx_q, 3'b000} +: 8] = byte_i;
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

   assign word_o      = word_q;
   assign word_done_o = byte_valid_i && (idx_q == 2'(NUM_LANES - 1));

endmodule

// File: rtl/instr_loader.sv
// Framed byte-serial loader writing words into instruction memory.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_loader
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_avail_i,
   output logic              rx_ack_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic              cpu_hold_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W:0]   word_count_o
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   loader_state_t     state_q, state_d;
   logic              rx_ack_q;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  count_inc;
   logic              accept, is_sync, in_rest, asm_valid, asm_clear, word_done;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   // rx_avail is ignored during the ack cycle, so one byte per two cycles at most.
   assign accept    = rx_avail_i && !rx_ack_q;
   assign is_sync   = (rx_data_i == SYNC_BYTE);
   assign in_rest   = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
   assign asm_valid = accept && (state_q == StData);
   assign asm_clear = accept && is_sync && in_rest;
   assign count_inc = count_q + CNT_W'(1);

   word_assembler u_word_assembler (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (asm_clear),
      .byte_valid_i (asm_valid),
      .byte_i       (rx_data_i),
      .word_o       (wr_data_o),
      .word_done_o  (word_done)
   );

   always_comb begin
      state_d   = state_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      count_d   = count_q;
      len_d     = len_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk_d     = chk_q;
`endif
      if (accept) begin
         unique case (state_q)
            StIdle, StDone, StErr: begin
               if (is_sync) begin
                  state_d = StLen;
                  count_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                  chk_d   = '0;
`endif
               end
            end
            StLen: begin
               if (rx_data_i == 8'd0 || 32'(rx_data_i) > DEPTH) begin
                  state_d = StErr;
               end else begin
                  len_d   = CNT_W'(rx_data_i);
                  state_d = StData;
               end
            end
            StData: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               chk_d = chk_q ^ rx_data_i;
`endif
               if (word_done) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = count_q[ADDR_W-1:0];
                  count_d   = count_inc;
                  if (count_inc == len_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                     state_d = StChk;
`else
                     state_d = StDone;
`endif
                  end
               end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            StChk: state_d = (rx_data_i == chk_q) ? StDone : StErr;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         rx_ack_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         count_q   <= '0;
         len_q     <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         chk_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         rx_ack_q  <= accept;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         count_q   <= count_d;
         len_q     <= len_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
         chk_q     <= chk_d;
`endif
      end
   end

   assign rx_ack_o     = rx_ack_q;
   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign word_count_o = count_q;
   assign cpu_hold_o   = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
   assign done_o       = (state_q == StDone);
   assign err_o        = (state_q == StErr);

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader; frame layout follows INSTR_LOADER_CHECKSUM_EN.
module tb_instr_loader;

   localparam int unsigned DEPTH  = 32;
   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_avail = 1'b0;
   logic              rx_ack, wr_en, cpu_hold, done, err;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [ADDR_W:0]   word_count;

   int unsigned       n_checks = 0;
   int unsigned       n_fail = 0;
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [31:0]       exp_data_q[$];
   logic              exp_hold = 1'b0;
   logic              prev_ack = 1'b0;
   bit                gaps_on = 1'b1;

   always #5 clk = ~clk;

   instr_loader #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .rx_data_i    (rx_data),
      .rx_avail_i   (rx_avail),
      .rx_ack_o     (rx_ack),
      .wr_en_o      (wr_en),
      .wr_addr_o    (wr_addr),
      .wr_data_o    (wr_data),
      .cpu_hold_o   (cpu_hold),
      .done_o       (done),
      .err_o        (err),
      .word_count_o (word_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cpu_hold", 64'(cpu_hold), 64'(exp_hold));
         check("rx_ack_not_back_to_back", 64'(prev_ack & rx_ack), 64'd0);
         if (wr_en) begin
            check("wr_en_with_rx_ack", 64'(rx_ack), 64'd1);
            check("write_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) begin
               check("wr_addr", 64'(wr_addr), 64'(exp_addr_q.pop_front()));
               check("wr_data", 64'(wr_data), 64'(exp_data_q.pop_front()));
            end
         end
      end
      prev_ack <= rx_ack;
   end

   // Presents a byte and returns at the edge that accepts it.
   task automatic send_byte(input logic [7:0] b, input logic hold_after);
      bit accepted = 1'b0;
      @(negedge clk);
      if (gaps_on) begin
         int gap = $urandom_range(0, 2);
         rx_avail = 1'b0;
         repeat (gap) @(negedge clk);
      end
      rx_avail = 1'b1;
      rx_data  = b;
      for (int n = 0; n < 8 && !accepted; n++) begin
         accepted = (rx_ack == 1'b0);
         @(posedge clk);
         if (!accepted) @(negedge clk);
      end
      check("byte_accepted", 64'(accepted), 64'd1);
      exp_hold = hold_after;
   endtask

   // pat: 0 random words, 1 all-0xA5 words, 2 fixed 0x00100013
   task automatic run_frame(input int len, input bit corrupt, input int pat);
      bit         ok_len = (len >= 1) && (len <= int'(DEPTH));
      bit         exp_bad_chk = 1'b0;
      logic [7:0] x = 8'h00;
      logic [7:0] bad;
      logic [31:0] w;
      send_byte(8'hA5, 1'b1);
      #1;
      check("sync_clears_done", 64'(done), 64'd0);
      check("sync_clears_err", 64'(err), 64'd0);
      check("sync_clears_count", 64'(word_count), 64'd0);
      send_byte(8'(len), ok_len);
      if (ok_len) begin
         for (int i = 0; i < len; i++) begin
            w = (pat == 1) ? 32'hA5A5A5A5 : (pat == 2) ? 32'h00100013 : $urandom;
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back(w);
            for (int k = 0; k < 4; k++) begin
               logic last = (i == len - 1) && (k == 3);
               x = x ^ w[8*k +: 8];
`ifdef INSTR_LOADER_CHECKSUM_EN
               send_byte(w[8*k +: 8], 1'b1);
`else
               send_byte(w[8*k +: 8], !last);
`endif
            end
         end
         bad = x ^ 8'h01;
         if (bad == 8'hA5) bad = x ^ 8'h02;
`ifdef INSTR_LOADER_CHECKSUM_EN
         send_byte(corrupt ? bad : x, 1'b0);
         exp_bad_chk = corrupt;
`else
         if (corrupt) send_byte(bad, 1'b0);
`endif
      end
      @(negedge clk);
      rx_avail = 1'b0;
      repeat (2) @(negedge clk);
      check("done", 64'(done), 64'(ok_len && !exp_bad_chk));
      check("err", 64'(err), 64'(!ok_len || exp_bad_chk));
      check("word_count", 64'(word_count), ok_len ? 64'(len) : 64'd0);
      check("writes_drained", 64'(exp_addr_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] w0;
      logic [31:0] w1;
      #3;
      check("reset_rx_ack", 64'(rx_ack), 64'd0);
      check("reset_wr_en", 64'(wr_en), 64'd0);
      check("reset_wr_addr", 64'(wr_addr), 64'd0);
      check("reset_wr_data", 64'(wr_data), 64'd0);
      check("reset_cpu_hold", 64'(cpu_hold), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_word_count", 64'(word_count), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      send_byte(8'h11, 1'b0);            // stray byte in IDLE is discarded
      run_frame(1, 1'b0, 2);
      run_frame(2, 1'b0, 0);
      run_frame(1, 1'b1, 0);
      run_frame(0, 1'b0, 0);
      run_frame(DEPTH + 1, 1'b0, 0);
      run_frame(1, 1'b0, 0);             // SYNC after ERR clears err

      gaps_on = 1'b0;                    // rx_avail held high across the frame
      run_frame(4, 1'b0, 0);
      run_frame(2, 1'b0, 1);
      gaps_on = 1'b1;
      run_frame(DEPTH, 1'b0, 0);

      // Reset mid-frame after six data bytes.
      gaps_on = 1'b0;
      w0 = $urandom;
      w1 = $urandom;
      exp_addr_q.push_back('0);
      exp_data_q.push_back(w0);
      send_byte(8'hA5, 1'b1);
      send_byte(8'd2, 1'b1);
      for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 1'b1);
      for (int k = 0; k < 2; k++) send_byte(w1[8*k +: 8], 1'b1);
      @(negedge clk);
      rx_avail = 1'b0;
      #2;
      exp_hold = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midreset_rx_ack", 64'(rx_ack), 64'd0);
      check("midreset_cpu_hold", 64'(cpu_hold), 64'd0);
      check("midreset_word_count", 64'(word_count), 64'd0);
      check("midreset_wr_data", 64'(wr_data), 64'd0);
      check("midreset_wr_addr", 64'(wr_addr), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("midreset_writes_drained", 64'(exp_addr_q.size()), 64'd0);
      gaps_on = 1'b1;
      run_frame(3, 1'b0, 0);

      for (int t = 0; t < 5; t++) begin
         run_frame(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), 0);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
